// File: rtl/fft_frame_loader_if.sv
// Sample, frame-status and read-port bundle of the FFT frame loader.
// The slave modport is the loader itself; the master is the source/core side.
interface fft_frame_loader_if #(
    parameter int DWL = 16,
    parameter int AWL = 11,
    parameter int NCH = 1
);
    localparam int LWL = $clog2(AWL + 1);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           EN;
    logic [LWL-1:0] i_LOG2N;
    logic [DWL-1:0] i_DATA_R;
    logic [DWL-1:0] i_DATA_I;
    logic           i_WR_DATA;
    logic           FULL;
    logic           o_OVERRUN;
    logic           o_FRAME_RDY;
    logic           o_FRAME_BANK;
    logic [LWL-1:0] o_LOG2N;
    logic           i_RD_EN;
    logic [CHW-1:0] i_RD_CH;
    logic [AWL-1:0] i_RD_ADDR;
    logic [DWL-1:0] o_DATA_R;
    logic [DWL-1:0] o_DATA_I;
    logic           o_RD_VALID;
    logic           i_FRAME_DONE;

    modport slave (
        input  EN, i_LOG2N, i_DATA_R, i_DATA_I, i_WR_DATA,
        input  i_RD_EN, i_RD_CH, i_RD_ADDR, i_FRAME_DONE,
        output FULL, o_OVERRUN, o_FRAME_RDY, o_FRAME_BANK, o_LOG2N,
        output o_DATA_R, o_DATA_I, o_RD_VALID
    );

    modport master (
        output EN, i_LOG2N, i_DATA_R, i_DATA_I, i_WR_DATA,
        output i_RD_EN, i_RD_CH, i_RD_ADDR, i_FRAME_DONE,
        input  FULL, o_OVERRUN, o_FRAME_RDY, o_FRAME_BANK, o_LOG2N,
        input  o_DATA_R, o_DATA_I, o_RD_VALID
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong input framer for the iterative FFT core: packs a sample stream into
// two banks of NCH channels each, and serves the oldest completed frame by random read.
module fft_frame_loader #(
    parameter int DWL              = 16,
    parameter int AWL              = 11,
    parameter int NCH              = 1,
    parameter int BIT_REVERS_WRITE = 0
) (
    input logic               CLK,
    input logic               RST,
    fft_frame_loader_if.slave bus
);
    localparam int LWL       = $clog2(AWL + 1);
    localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SLOTS     = 2 * NCH;
    localparam int SW        = $clog2(SLOTS);
    localparam int MEM_WORDS = SLOTS * (1 << AWL);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_READY
    } bank_state_t;

    bank_state_t    state_q   [2];
    bank_state_t    state_d   [2];
    logic [LWL-1:0] log2n_q   [2];
    logic [LWL-1:0] log2n_d   [2];
    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [CHW-1:0] ch_cnt_q, ch_cnt_d;
    logic [AWL-1:0] idx_cnt_q, idx_cnt_d;
    logic           overrun_q, overrun_d;

    logic [DWL-1:0] rd_data_r_q, rd_data_i_q;
    logic           rd_valid_q;

    logic [2*DWL-1:0] mem [MEM_WORDS];

    logic           full, frame_rdy, first_wr, last_wr;
    logic           wr_fire, rd_fire, frame_release;
    logic [LWL-1:0] req_log2n, cur_log2n;
    logic [AWL-1:0] last_idx, wr_k;
    logic [SW-1:0]  wr_slot, rd_slot;
    logic [SW+AWL-1:0] wr_addr, rd_addr;

    // Reverses the low n bits of k: full-width reverse, then shift the result down.
    function automatic logic [AWL-1:0] bitrev(input logic [AWL-1:0] k, input logic [LWL-1:0] n);
        logic [AWL-1:0] r;
        for (int i = 0; i < AWL; i++) r[i] = k[AWL-1-i];
        return r >> (LWL'(AWL) - n);
    endfunction

    assign full      = (state_q[wr_bank_q] == BANK_READY);
    assign frame_rdy = (state_q[rd_bank_q] == BANK_READY);
    assign first_wr  = (state_q[wr_bank_q] == BANK_EMPTY);

    // A fresh frame takes its length from the port; a partial frame keeps the latched one.
    assign req_log2n = (bus.i_LOG2N == '0 || bus.i_LOG2N > LWL'(AWL)) ? LWL'(AWL) : bus.i_LOG2N;
    assign cur_log2n = first_wr ? req_log2n : log2n_q[wr_bank_q];
    assign last_idx  = {AWL{1'b1}} >> (LWL'(AWL) - cur_log2n);
    assign last_wr   = (ch_cnt_q == CHW'(NCH - 1)) && (idx_cnt_q == last_idx);

    assign wr_fire       = bus.EN && bus.i_WR_DATA && !full;
    assign rd_fire       = bus.EN && bus.i_RD_EN && frame_rdy;
    assign frame_release = bus.EN && bus.i_FRAME_DONE && frame_rdy;

    assign wr_k    = (BIT_REVERS_WRITE != 0) ? bitrev(idx_cnt_q, cur_log2n) : idx_cnt_q;
    assign wr_slot = wr_bank_q ? SW'(NCH) + SW'(ch_cnt_q) : SW'(ch_cnt_q);
    assign rd_slot = rd_bank_q ? SW'(NCH) + SW'(bus.i_RD_CH) : SW'(bus.i_RD_CH);
    assign wr_addr = {wr_slot, wr_k};
    assign rd_addr = {rd_slot, bus.i_RD_ADDR};

    // NOTE: every variable gets its hold value first so no path leaves it unassigned
    // and no latch is inferred; blocking '=' is correct only inside always_comb.
    always_comb begin
        state_d   = state_q;
        log2n_d   = log2n_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        ch_cnt_d  = ch_cnt_q;
        idx_cnt_d = idx_cnt_q;
        overrun_d = overrun_q | (bus.EN && bus.i_WR_DATA && full);

        if (wr_fire) begin
            if (first_wr) log2n_d[wr_bank_q] = req_log2n;
            if (last_wr) begin
                state_d[wr_bank_q] = BANK_READY;
                wr_bank_d          = ~wr_bank_q;
                ch_cnt_d           = '0;
                idx_cnt_d          = '0;
            end else begin
                state_d[wr_bank_q] = BANK_FILLING;
                if (ch_cnt_q == CHW'(NCH - 1)) begin
                    ch_cnt_d  = '0;
                    idx_cnt_d = idx_cnt_q + 1'b1;
                end else begin
                    ch_cnt_d  = ch_cnt_q + 1'b1;
                end
            end
        end

        // A releasable bank is READY, so it can never be the bank being written above.
        if (frame_release) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= '{default: BANK_EMPTY};
            log2n_q   <= '{default: '0};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ch_cnt_q  <= '0;
            idx_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            log2n_q   <= log2n_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ch_cnt_q  <= ch_cnt_d;
            idx_cnt_q <= idx_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the frame memory has no reset so it maps onto block RAM; stale words are harmless.
    always_ff @(posedge CLK) begin
        if (wr_fire) mem[wr_addr] <= {bus.i_DATA_R, bus.i_DATA_I};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_valid_q  <= 1'b0;
            rd_data_r_q <= '0;
            rd_data_i_q <= '0;
        end else if (bus.EN) begin
            rd_valid_q <= rd_fire;
            if (rd_fire) {rd_data_r_q, rd_data_i_q} <= mem[rd_addr];
        end
    end

    assign bus.FULL         = full;
    assign bus.o_OVERRUN    = overrun_q;
    assign bus.o_FRAME_RDY  = frame_rdy;
    assign bus.o_FRAME_BANK = rd_bank_q;
    assign bus.o_LOG2N      = log2n_q[rd_bank_q];
    assign bus.o_DATA_R     = rd_data_r_q;
    assign bus.o_DATA_I     = rd_data_i_q;
    assign bus.o_RD_VALID   = rd_valid_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboard bench for fft_frame_loader: three instances (plain, bit-reversed, two-channel)
// share one stimulus bus; only the selected instance is enabled and observed.
module tb_fft_frame_loader;
    localparam int DWL = 16;
    localparam int AWL = 4;
    localparam int LWL = $clog2(AWL + 1);

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    logic           en, wr, rd_en, rd_ch, done;
    logic [LWL-1:0] log2n;
    logic [DWL-1:0] dr, di;
    logic [AWL-1:0] rd_addr;

    logic           full_o, ovr_o, rdy_o, bank_o, valid_o;
    logic [LWL-1:0] log2n_o;
    logic [DWL-1:0] dr_o, di_o;

    logic [2*DWL-1:0] sb_q [$];

    fft_frame_loader_if #(.DWL(DWL), .AWL(AWL), .NCH(1)) if_a ();
    fft_frame_loader_if #(.DWL(DWL), .AWL(AWL), .NCH(1)) if_b ();
    fft_frame_loader_if #(.DWL(DWL), .AWL(AWL), .NCH(2)) if_c ();

    assign if_a.EN = en && (sel == 0);
    assign if_b.EN = en && (sel == 1);
    assign if_c.EN = en && (sel == 2);
    assign if_a.i_LOG2N = log2n;   assign if_b.i_LOG2N = log2n;   assign if_c.i_LOG2N = log2n;
    assign if_a.i_DATA_R = dr;     assign if_b.i_DATA_R = dr;     assign if_c.i_DATA_R = dr;
    assign if_a.i_DATA_I = di;     assign if_b.i_DATA_I = di;     assign if_c.i_DATA_I = di;
    assign if_a.i_WR_DATA = wr;    assign if_b.i_WR_DATA = wr;    assign if_c.i_WR_DATA = wr;
    assign if_a.i_RD_EN = rd_en;   assign if_b.i_RD_EN = rd_en;   assign if_c.i_RD_EN = rd_en;
    assign if_a.i_RD_CH = rd_ch;   assign if_b.i_RD_CH = rd_ch;   assign if_c.i_RD_CH = rd_ch;
    assign if_a.i_RD_ADDR = rd_addr; assign if_b.i_RD_ADDR = rd_addr; assign if_c.i_RD_ADDR = rd_addr;
    assign if_a.i_FRAME_DONE = done; assign if_b.i_FRAME_DONE = done; assign if_c.i_FRAME_DONE = done;

    fft_frame_loader #(.DWL(DWL), .AWL(AWL), .NCH(1), .BIT_REVERS_WRITE(0))
        dut_a (.CLK(CLK), .RST(RST), .bus(if_a.slave));
    fft_frame_loader #(.DWL(DWL), .AWL(AWL), .NCH(1), .BIT_REVERS_WRITE(1))
        dut_b (.CLK(CLK), .RST(RST), .bus(if_b.slave));
    fft_frame_loader #(.DWL(DWL), .AWL(AWL), .NCH(2), .BIT_REVERS_WRITE(0))
        dut_c (.CLK(CLK), .RST(RST), .bus(if_c.slave));

    always_comb begin
        {full_o, ovr_o, rdy_o, bank_o, valid_o, log2n_o, dr_o, di_o} =
            {if_a.FULL, if_a.o_OVERRUN, if_a.o_FRAME_RDY, if_a.o_FRAME_BANK, if_a.o_RD_VALID,
             if_a.o_LOG2N, if_a.o_DATA_R, if_a.o_DATA_I};
        if (sel == 1)
            {full_o, ovr_o, rdy_o, bank_o, valid_o, log2n_o, dr_o, di_o} =
                {if_b.FULL, if_b.o_OVERRUN, if_b.o_FRAME_RDY, if_b.o_FRAME_BANK, if_b.o_RD_VALID,
                 if_b.o_LOG2N, if_b.o_DATA_R, if_b.o_DATA_I};
        else if (sel == 2)
            {full_o, ovr_o, rdy_o, bank_o, valid_o, log2n_o, dr_o, di_o} =
                {if_c.FULL, if_c.o_OVERRUN, if_c.o_FRAME_RDY, if_c.o_FRAME_BANK, if_c.o_RD_VALID,
                 if_c.o_LOG2N, if_c.o_DATA_R, if_c.o_DATA_I};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr = 1'b1;
            dr = DWL'(base + i);
            di = ~DWL'(base + i);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic issue_read(input logic ch, input int addr, input int exp_r);
        rd_en   = 1'b1;
        rd_ch   = ch;
        rd_addr = AWL'(addr);
        sb_q.push_back({DWL'(exp_r), ~DWL'(exp_r)});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic frame_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
        check("sb_drain", sb_q.size(), 0);
        check("rd_valid_idle", valid_o, 1'b0);
    endtask

    task automatic expect_status(input string tag, input logic rdy, input logic full, input logic bank);
        check({tag, "_rdy"}, rdy_o, rdy);
        check({tag, "_full"}, full_o, full);
        check({tag, "_bank"}, bank_o, bank);
    endtask

    task automatic do_reset();
        en = 1'b1; wr = 1'b0; rd_en = 1'b0; done = 1'b0; rd_ch = 1'b0;
        RST = 1'b1;
        #1;
        check("rst_full", full_o, 1'b0);
        check("rst_ovr", ovr_o, 1'b0);
        check("rst_rdy", rdy_o, 1'b0);
        check("rst_bank", bank_o, 1'b0);
        check("rst_log2n", log2n_o, 0);
        check("rst_data", {dr_o, di_o}, 0);
        check("rst_valid", valid_o, 1'b0);
        tick();
        tick();
        RST = 1'b0;
        sb_q.delete();
    endtask

    // Read data is checked in arrival order against expectations queued at issue time.
    always @(negedge CLK) begin
        logic [2*DWL-1:0] exp_w;
        if (!RST && valid_o) begin
            if (sb_q.size() == 0) check("rd_spurious_valid", valid_o, 1'b0);
            else begin
                exp_w = sb_q.pop_front();
                check("rd_data", {dr_o, di_o}, exp_w);
            end
        end
    end

    initial begin
        static int rev3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        static logic [LWL-1:0] lens [3] = '{3'd4, 3'd0, 3'd5};
        en = 1'b0; wr = 1'b0; rd_en = 1'b0; rd_ch = 1'b0; done = 1'b0;
        log2n = '0; dr = '0; di = '0; rd_addr = '0;
        tick();

        // Basic frame, read latency, EN freeze, release.
        sel = 0;
        do_reset();
        log2n = 3'd3;
        write_n(0, 7);
        expect_status("pre_last", 1'b0, 1'b0, 1'b0);
        write_n(7, 1);
        expect_status("frame0", 1'b1, 1'b0, 1'b0);
        check("frame0_log2n", log2n_o, 3);
        issue_read(1'b0, 0, 0);
        check("rd_latency", valid_o, 1'b1);
        for (int a = 1; a < 8; a++) issue_read(1'b0, a, a);
        drain();
        en = 1'b0; wr = 1'b1; rd_en = 1'b1; done = 1'b1;
        tick();
        wr = 1'b0; rd_en = 1'b0; done = 1'b0; en = 1'b1;
        expect_status("en_freeze", 1'b1, 1'b0, 1'b0);
        check("en_freeze_valid", valid_o, 1'b0);
        check("en_freeze_ovr", ovr_o, 1'b0);
        frame_done();
        check("done_rdy", rdy_o, 1'b0);

        // Ping-pong: both banks full, overrun, release.
        do_reset();
        log2n = 3'd3;
        write_n(100, 16);
        expect_status("both_full", 1'b1, 1'b1, 1'b0);
        check("ovr_before", ovr_o, 1'b0);
        write_n(999, 1);
        check("ovr_set", ovr_o, 1'b1);
        frame_done();
        expect_status("pp_release", 1'b1, 1'b0, 1'b1);
        check("ovr_sticky", ovr_o, 1'b1);
        for (int a = 0; a < 8; a++) issue_read(1'b0, a, 108 + a);
        drain();

        // Last write, release and read of the released bank on one edge.
        do_reset();
        log2n = 3'd3;
        write_n(0, 8);
        write_n(10, 7);
        expect_status("sim_pre", 1'b1, 1'b0, 1'b0);
        wr = 1'b1; dr = DWL'(17); di = ~DWL'(17); done = 1'b1;
        rd_en = 1'b1; rd_ch = 1'b0; rd_addr = AWL'(2);
        sb_q.push_back({DWL'(2), ~DWL'(2)});
        tick();
        wr = 1'b0; done = 1'b0; rd_en = 1'b0;
        expect_status("sim_post", 1'b1, 1'b0, 1'b1);
        check("sim_log2n", log2n_o, 3);
        issue_read(1'b0, 7, 17);
        issue_read(1'b0, 0, 10);
        drain();

        // Bit-reversed write order.
        sel = 1;
        do_reset();
        log2n = 3'd3;
        write_n(0, 8);
        expect_status("brev", 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 8; a++) issue_read(1'b0, a, rev3[a]);
        drain();

        // Two interleaved channels.
        sel = 2;
        do_reset();
        log2n = 3'd2;
        write_n(0, 7);
        check("nch2_pre_rdy", rdy_o, 1'b0);
        write_n(7, 1);
        check("nch2_rdy", rdy_o, 1'b1);
        check("nch2_log2n", log2n_o, 2);
        for (int a = 0; a < 4; a++) issue_read(1'b0, a, 2 * a);
        for (int a = 0; a < 4; a++) issue_read(1'b1, a, 2 * a + 1);
        drain();

        // Run-time length: latched at first write, 0 and >AWL mean AWL.
        sel = 0;
        do_reset();
        log2n = 3'd2;
        write_n(0, 2);
        log2n = 3'd4;
        write_n(2, 1);
        check("len2_pre_rdy", rdy_o, 1'b0);
        write_n(3, 1);
        check("len2_rdy", rdy_o, 1'b1);
        check("len2_log2n", log2n_o, 2);
        frame_done();
        for (int t = 0; t < 3; t++) begin
            log2n = lens[t];
            write_n(50, 15);
            check($sformatf("len_%0d_pre_rdy", lens[t]), rdy_o, 1'b0);
            write_n(65, 1);
            check($sformatf("len_%0d_rdy", lens[t]), rdy_o, 1'b1);
            check($sformatf("len_%0d_log2n", lens[t]), log2n_o, AWL);
            frame_done();
        end

        // Reset mid-frame discards the partial frame.
        do_reset();
        log2n = 3'd3;
        write_n(0, 5);
        do_reset();
        write_n(200, 7);
        check("post_rst_pre_rdy", rdy_o, 1'b0);
        write_n(207, 1);
        expect_status("post_rst", 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 8; a++) issue_read(1'b0, a, 200 + a);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
